// File: rtl/avalon_mem_master_if.sv
// Avalon-MM data-memory bus between the CPU load/store master and RAM / mapped slaves.
// The master drives the command side; the slave returns readdata and waitrequest.

interface avalon_mem_master_if;
   logic [31:0] address;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic [31:0] readdata;
   logic        waitrequest;

   modport master (
      output address, read, write, writedata, byteenable,
      input  readdata, waitrequest
   );

   modport slave (
      input  address, read, write, writedata, byteenable,
      output readdata, waitrequest
   );
endinterface

// File: rtl/avalon_mem_master.sv
// Turns one CPU load/store into a single Avalon read or write with byte lanes,
// waitrequest handling, stall timeout and sign/zero-extended load return.

module avalon_mem_master #(
   parameter int unsigned READ_LATENCY = 1,
   parameter int unsigned TIMEOUT      = 255
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       cpu_req,
   input  logic                       cpu_we,
   input  logic [1:0]                 cpu_size,
   input  logic                       cpu_signed,
   input  logic [31:0]                cpu_addr,
   input  logic [31:0]                cpu_wdata,
   output logic                       cpu_busy,
   output logic                       cpu_done,
   output logic                       cpu_err,
   output logic [31:0]                cpu_rdata,
   avalon_mem_master_if.master        bus
);

   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StReq    = 3'd1;
   localparam logic [2:0] StRdWait = 3'd2;
   localparam logic [2:0] StDone   = 3'd3;
   localparam logic [2:0] StErr    = 3'd4;

   localparam int unsigned ToW  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam int unsigned LatW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [ToW-1:0]  ToLast  = ToW'(TIMEOUT - 1);
   localparam logic [LatW-1:0] LatLast = LatW'(READ_LATENCY - 1);

   logic [2:0]      state_q, state_d;
   logic            we_q, we_d;
   logic [1:0]      size_q, size_d;
   logic            sgn_q, sgn_d;
   logic [1:0]      lane_q, lane_d;
   logic [ToW-1:0]  to_cnt_q, to_cnt_d;
   logic [LatW-1:0] lat_q, lat_d;
   logic [31:0]     address_q, address_d;
   logic            read_q, read_d;
   logic            write_q, write_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [3:0]      be_q, be_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic [31:0]     rdata_q, rdata_d;

   logic            misaligned;
   logic [3:0]      be_acc;
   logic [31:0]     wd_acc;
   logic [31:0]     rd_shift;
   logic [31:0]     load_ext;

   // Lane decode of the incoming request; data is masked to its size before shifting.
   always_comb begin
      misaligned = 1'b0;
      be_acc     = 4'b1111;
      wd_acc     = cpu_wdata;
      unique case (cpu_size)
         2'b00: begin
            be_acc = 4'b0001 << cpu_addr[1:0];
            wd_acc = {24'd0, cpu_wdata[7:0]} << {cpu_addr[1:0], 3'b000};
         end
         2'b01: begin
            misaligned = cpu_addr[0];
            be_acc     = 4'b0011 << cpu_addr[1:0];
            wd_acc     = {16'd0, cpu_wdata[15:0]} << {cpu_addr[1:0], 3'b000};
         end
         2'b10: misaligned = |cpu_addr[1:0];
         default: misaligned = 1'b1;
      endcase
   end

   assign rd_shift = bus.readdata >> {lane_q, 3'b000};

   always_comb begin
      unique case (size_q)
         2'b00:   load_ext = {{24{sgn_q & rd_shift[7]}}, rd_shift[7:0]};
         2'b01:   load_ext = {{16{sgn_q & rd_shift[15]}}, rd_shift[15:0]};
         default: load_ext = rd_shift;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      we_d      = we_q;
      size_d    = size_q;
      sgn_d     = sgn_q;
      lane_d    = lane_q;
      to_cnt_d  = to_cnt_q;
      lat_d     = lat_q;
      address_d = address_q;
      read_d    = read_q;
      write_d   = write_q;
      wdata_d   = wdata_q;
      be_d      = be_q;
      rdata_d   = rdata_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (cpu_req) begin
               we_d     = cpu_we;
               size_d   = cpu_size;
               sgn_d    = cpu_signed;
               lane_d   = cpu_addr[1:0];
               to_cnt_d = '0;
               lat_d    = '0;
               if (misaligned) begin
                  state_d = StErr;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
               end else begin
                  state_d   = StReq;
                  address_d = {cpu_addr[31:2], 2'b00};
                  be_d      = be_acc;
                  wdata_d   = cpu_we ? wd_acc : 32'd0;
                  read_d    = ~cpu_we;
                  write_d   = cpu_we;
               end
            end
         end
         StReq: begin
            if (!bus.waitrequest) begin
               read_d  = 1'b0;
               write_d = 1'b0;
               if (we_q) begin
                  state_d = StDone;
                  done_d  = 1'b1;
               end else begin
                  state_d = StRdWait;
               end
            end else if (TIMEOUT != 0 && to_cnt_q == ToLast) begin
               // Slave never released the bus: abandon without touching cpu_rdata.
               read_d  = 1'b0;
               write_d = 1'b0;
               state_d = StDone;
               done_d  = 1'b1;
               err_d   = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         StRdWait: begin
            if (lat_q == LatLast) begin
               rdata_d = load_ext;
               state_d = StDone;
               done_d  = 1'b1;
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         StDone, StErr: state_d = StIdle;
         default:       state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         we_q      <= 1'b0;
         size_q    <= 2'b00;
         sgn_q     <= 1'b0;
         lane_q    <= 2'b00;
         to_cnt_q  <= '0;
         lat_q     <= '0;
         address_q <= 32'd0;
         read_q    <= 1'b0;
         write_q   <= 1'b0;
         wdata_q   <= 32'd0;
         be_q      <= 4'd0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= 32'd0;
      end else begin
         state_q   <= state_d;
         we_q      <= we_d;
         size_q    <= size_d;
         sgn_q     <= sgn_d;
         lane_q    <= lane_d;
         to_cnt_q  <= to_cnt_d;
         lat_q     <= lat_d;
         address_q <= address_d;
         read_q    <= read_d;
         write_q   <= write_d;
         wdata_q   <= wdata_d;
         be_q      <= be_d;
         done_q    <= done_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
      end
   end

   assign bus.address    = address_q;
   assign bus.read       = read_q;
   assign bus.write      = write_q;
   assign bus.writedata  = wdata_q;
   assign bus.byteenable = be_q;

   assign cpu_busy  = (state_q != StIdle);
   assign cpu_done  = done_q;
   assign cpu_err   = err_q;
   assign cpu_rdata = rdata_q;

endmodule

// File: tb/tb_avalon_mem_master.sv
// Scoreboard bench for avalon_mem_master: directed transactions push expected results,
// a negedge monitor checks bus activity, timing and CPU-side results.

module tb_avalon_mem_master;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          lat;
      int          strobes;
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      int          issue;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [1:0]  cpu_size = 2'b00;
   logic        cpu_signed = 1'b0;
   logic [31:0] cpu_addr = 32'd0;
   logic [31:0] cpu_wdata = 32'd0;
   logic        cpu_busy;
   logic        cpu_done;
   logic        cpu_err;
   logic [31:0] cpu_rdata;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          stall_set = 0;
   int          stall_cnt = 0;
   logic        rd_valid = 1'b0;
   logic        rst_at_edge = 1'b0;
   logic [31:0] rd_value = 32'd0;
   exp_t        sb[$];

   avalon_mem_master_if bus ();

   avalon_mem_master #(
      .READ_LATENCY(1),
      .TIMEOUT     (8)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_size   (cpu_size),
      .cpu_signed (cpu_signed),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_busy   (cpu_busy),
      .cpu_done   (cpu_done),
      .cpu_err    (cpu_err),
      .cpu_rdata  (cpu_rdata),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   // Slave model: stall_set waitrequest cycles per strobe, readdata valid one cycle after accept.
   always @(posedge clk) begin
      cyc         <= cyc + 1;
      rst_at_edge <= !reset_n;
      rd_valid    <= bus.read && !bus.waitrequest;
      if (bus.read || bus.write) begin
         if (bus.waitrequest) stall_cnt <= stall_cnt + 1;
      end else begin
         stall_cnt <= 0;
      end
   end

   assign bus.waitrequest = (bus.read || bus.write) && (stall_cnt < stall_set);
   assign bus.readdata    = rd_valid ? rd_value : 32'h5A5A5A5A;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor
   initial begin
      int          strobes;
      int          busy_cyc;
      logic [31:0] o_addr;
      logic [31:0] o_wdata;
      logic [3:0]  o_be;
      logic        o_we;
      exp_t        e;
      strobes  = 0;
      busy_cyc = 0;
      o_addr   = 32'd0;
      o_wdata  = 32'd0;
      o_be     = 4'd0;
      o_we     = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_at_edge) begin
            chk("rst_strobes", {30'd0, bus.read, bus.write}, 32'd0);
            chk("rst_status", {29'd0, cpu_busy, cpu_done, cpu_err}, 32'd0);
            chk("rst_rdata", cpu_rdata, 32'd0);
            chk("rst_bus", bus.address | bus.writedata | {28'd0, bus.byteenable}, 32'd0);
            strobes  = 0;
            busy_cyc = 0;
         end else begin
            chk("rd_wr_excl", {31'd0, bus.read & bus.write}, 32'd0);
            chk("err_wo_done", {31'd0, cpu_err & ~cpu_done}, 32'd0);
            if (bus.read || bus.write) begin
               if (strobes == 0) begin
                  o_addr  = bus.address;
                  o_wdata = bus.writedata;
                  o_be    = bus.byteenable;
                  o_we    = bus.write;
               end else begin
                  chk("stable_addr", bus.address, o_addr);
                  chk("stable_be", {28'd0, bus.byteenable}, {28'd0, o_be});
                  chk("stable_wdata", bus.writedata, o_wdata);
               end
               strobes++;
            end
            if (cpu_busy) busy_cyc++;
            if (cpu_done) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
               end else begin
                  e = sb.pop_front();
                  chk("err", {31'd0, cpu_err}, {31'd0, e.err});
                  chk("rdata", cpu_rdata, e.rdata);
                  chk("latency", cyc - e.issue, e.lat);
                  chk("busy_cycles", busy_cyc, e.lat);
                  chk("strobe_cycles", strobes, e.strobes);
                  if (e.strobes > 0) begin
                     chk("bus_we", {31'd0, o_we}, {31'd0, e.we});
                     chk("address", o_addr, e.addr);
                     chk("byteenable", {28'd0, o_be}, {28'd0, e.be});
                     if (e.we) chk("writedata", o_wdata, e.wdata);
                  end
               end
               strobes  = 0;
               busy_cyc = 0;
            end
         end
      end
   end

   task automatic run(input logic we, input logic [1:0] size, input logic sgn,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] rdv, input int stalls,
                      input logic x_err, input logic [31:0] x_rdata, input int x_lat,
                      input int x_strobes, input logic [31:0] x_addr,
                      input logic [3:0] x_be, input logic [31:0] x_wdata);
      exp_t e;
      int   n;
      @(negedge clk);
      stall_set  = stalls;
      rd_value   = rdv;
      cpu_req    = 1'b1;
      cpu_we     = we;
      cpu_size   = size;
      cpu_signed = sgn;
      cpu_addr   = addr;
      cpu_wdata  = wdata;
      e.err      = x_err;
      e.rdata    = x_rdata;
      e.lat      = x_lat;
      e.strobes  = x_strobes;
      e.we       = we;
      e.addr     = x_addr;
      e.be       = x_be;
      e.wdata    = x_wdata;
      e.issue    = cyc;
      sb.push_back(e);
      @(negedge clk);
      cpu_req = 1'b0;
      n = 0;
      while (sb.size() != 0 && n < 40) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL txn_wait: got no done within 40 cycles expected done for addr %h", addr);
         sb.delete();
      end
   endtask

   // Stimulus
   initial begin
      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      // Stores: word, byte at lane 3 (upper junk must be masked), half at lane 2
      run(1, 2'b10, 0, 32'hBFC00010, 32'hDEADBEEF, 0, 0,
          0, 32'h00000000, 2, 1, 32'hBFC00010, 4'b1111, 32'hDEADBEEF);
      run(1, 2'b00, 0, 32'hBFC00003, 32'h123456AB, 0, 0,
          0, 32'h00000000, 2, 1, 32'hBFC00000, 4'b1000, 32'hAB000000);
      run(1, 2'b01, 0, 32'hBFC00002, 32'hFFFFCAFE, 0, 0,
          0, 32'h00000000, 2, 1, 32'hBFC00000, 4'b1100, 32'hCAFE0000);

      // Loads with sign/zero extension across lanes
      run(0, 2'b00, 1, 32'hBFC00007, 0, 32'h80123456, 0,
          0, 32'hFFFFFF80, 3, 1, 32'hBFC00004, 4'b1000, 0);
      run(0, 2'b00, 0, 32'hBFC00007, 0, 32'h80123456, 0,
          0, 32'h00000080, 3, 1, 32'hBFC00004, 4'b1000, 0);
      run(0, 2'b01, 1, 32'hBFC00006, 0, 32'h80011234, 0,
          0, 32'hFFFF8001, 3, 1, 32'hBFC00004, 4'b1100, 0);
      run(0, 2'b01, 0, 32'hBFC00004, 0, 32'h1234F00F, 0,
          0, 32'h0000F00F, 3, 1, 32'hBFC00004, 4'b0011, 0);
      run(0, 2'b00, 1, 32'hBFC00001, 0, 32'h00007F00, 0,
          0, 32'h0000007F, 3, 1, 32'hBFC00000, 4'b0010, 0);

      // Word load stalled 3 cycles; signed flag ignored
      run(0, 2'b10, 1, 32'hBFC00020, 0, 32'h89ABCDEF, 3,
          0, 32'h89ABCDEF, 6, 4, 32'hBFC00020, 4'b1111, 0);

      // Misaligned / illegal: no strobe, done+err next cycle, rdata held
      run(0, 2'b01, 1, 32'hBFC00001, 0, 0, 0, 1, 32'h89ABCDEF, 1, 0, 0, 0, 0);
      run(0, 2'b10, 0, 32'hBFC00002, 0, 0, 0, 1, 32'h89ABCDEF, 1, 0, 0, 0, 0);
      run(0, 2'b11, 0, 32'hBFC00000, 0, 0, 0, 1, 32'h89ABCDEF, 1, 0, 0, 0, 0);
      run(1, 2'b01, 0, 32'hBFC00003, 32'h0000FFFF, 0, 0, 1, 32'h89ABCDEF, 1, 0, 0, 0, 0);

      // Stuck waitrequest: 8 stall cycles then abort with err
      run(0, 2'b10, 0, 32'hBFC00030, 0, 32'h55555555, 1000,
          1, 32'h89ABCDEF, 9, 8, 32'hBFC00030, 4'b1111, 0);

      // Reset while stalled: strobes gone after the edge, no done pulse
      @(negedge clk);
      stall_set = 1000;
      cpu_req   = 1'b1;
      cpu_we    = 1'b0;
      cpu_size  = 2'b10;
      cpu_addr  = 32'hBFC00050;
      @(negedge clk);
      cpu_req = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n   = 1'b1;
      stall_set = 0;

      // Traffic resumes; a store afterwards leaves cpu_rdata alone
      run(0, 2'b10, 0, 32'hBFC00040, 0, 32'h11223344, 0,
          0, 32'h11223344, 3, 1, 32'hBFC00040, 4'b1111, 0);
      run(1, 2'b10, 0, 32'hBFC00044, 32'hA5A5A5A5, 0, 0,
          0, 32'h11223344, 2, 1, 32'hBFC00044, 4'b1111, 32'hA5A5A5A5);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
